// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART-to-AES frame controller.
package uart_ctrl_pkg;

  localparam int         BLK_W        = 128;
  localparam logic [7:0] CMD_KEY_DEF  = 8'hA5;
  localparam logic [7:0] CMD_DATA_DEF = 8'h5A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    ISSUE = 2'd2
  } state_t;

endpackage

// File: rtl/uart_frame_ctrl_timer.sv
// Inter-byte timeout counter for uart_frame_ctrl; only instantiated when RX_TIMEOUT_EN is defined.
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == LAST);
  assign o_expire  = i_enable && w_at_last;

  // Saturates at LAST so a stalled enable cannot wrap into a false early expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_at_last) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Assembles a command byte plus BYTES_PER_BLK payload bytes into one AES frame.
// Optional inter-byte timeout is compiled in with `define RX_TIMEOUT_EN.
module uart_frame_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int         BYTES_PER_BLK  = BLK_W / 8,
  parameter logic [7:0] CMD_KEY        = CMD_KEY_DEF,
  parameter logic [7:0] CMD_DATA       = CMD_DATA_DEF,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   rx_byte,
  input  logic                         rx_done,
  input  logic                         blk_ready,
  output logic [8*BYTES_PER_BLK-1:0]   blk_data,
  output logic                         blk_is_key,
  output logic                         blk_valid,
  output logic                         busy,
  output logic                         err_cmd,
  output logic                         err_ovr,
  output logic                         err_tmo,
  output logic [1:0]                   dbg_state
);

  localparam int FW    = 8 * BYTES_PER_BLK;
  localparam int CNT_W = (BYTES_PER_BLK > 1) ? $clog2(BYTES_PER_BLK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_BLK - 1);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [FW-1:0]    r_frame;
  logic             r_is_key;
  logic             r_err_cmd;
  logic             r_err_ovr;
  logic             w_is_cmd;
  logic             w_last_byte;
  logic             w_expire;

  assign w_is_cmd    = (rx_byte == CMD_KEY) || (rx_byte == CMD_DATA);
  assign w_last_byte = (r_cnt == CNT_LAST);

`ifdef RX_TIMEOUT_EN
  logic r_err_tmo;

  frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  ((r_state == IDLE) || rx_done),
    .i_enable (r_state == RECV),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_err_tmo <= 1'b0;
    else        r_err_tmo <= (r_state == RECV) && w_expire && !rx_done;
  end

  assign err_tmo = r_err_tmo;
`else
  assign w_expire = 1'b0;
  assign err_tmo  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (rx_done && w_is_cmd) w_next = RECV;
      RECV: begin
        if (rx_done && w_last_byte) w_next = ISSUE;
        else if (!rx_done && w_expire) w_next = IDLE;
      end
      ISSUE:   if (blk_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake: blk_valid holds with blk_data/blk_is_key frozen until a cycle
  // where blk_valid && blk_ready; that cycle transfers the frame.
  always_comb begin
    blk_valid = (r_state == ISSUE);
    busy      = (r_state != IDLE);
    dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_frame   <= '0;
      r_is_key  <= 1'b0;
      r_err_cmd <= 1'b0;
      r_err_ovr <= 1'b0;
    end else begin
      r_err_cmd <= (r_state == IDLE)  && rx_done && !w_is_cmd;
      r_err_ovr <= (r_state == ISSUE) && rx_done;
      if (r_state == IDLE && rx_done && w_is_cmd) begin
        r_is_key <= (rx_byte == CMD_KEY);
        r_cnt    <= '0;
      end else if (r_state == RECV && rx_done) begin
        r_frame <= {r_frame[FW-9:0], rx_byte};
        r_cnt   <= w_last_byte ? '0 : r_cnt + 1'b1;
      end else if (r_state == RECV && w_expire) begin
        r_frame <= '0;
        r_cnt   <= '0;
      end
    end
  end

  assign blk_data   = r_frame;
  assign blk_is_key = r_is_key;
  assign err_cmd    = r_err_cmd;
  assign err_ovr    = r_err_ovr;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed self-checking bench for uart_frame_ctrl (timeout scenario when RX_TIMEOUT_EN is defined).
module tb_uart_frame_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         rx_done = 1'b0;
  logic         blk_ready = 1'b0;
  logic [127:0] blk_data;
  logic         blk_is_key, blk_valid, busy, err_cmd, err_ovr, err_tmo;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  uart_frame_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_done(rx_done),
    .blk_ready(blk_ready), .blk_data(blk_data), .blk_is_key(blk_is_key),
    .blk_valid(blk_valid), .busy(busy), .err_cmd(err_cmd), .err_ovr(err_ovr),
    .err_tmo(err_tmo), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe held for exactly one sampling edge; returns 1ns after that edge.
  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_byte = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic send_payload(input logic [7:0] first);
    for (int i = 0; i < 16; i++) send_byte(first + 8'(i));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #23;
    n_checks++;
    if ({blk_valid, busy, blk_is_key, err_cmd, err_ovr, err_tmo} !== 6'b0 || blk_data !== 128'h0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b busy=%b key=%b errs=%b%b%b data=%h state=%0d, required all 0",
               blk_valid, busy, blk_is_key, err_cmd, err_ovr, err_tmo, blk_data, dbg_state);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_key_frame();
    blk_ready = 1'b1;
    send_byte(8'hA5);
    n_checks++;
    if (busy !== 1'b1 || dbg_state !== 2'd1) begin
      n_fail++; $display("FAIL key_enter_recv: busy=%b state=%0d, required 1/1", busy, dbg_state);
    end
    send_payload(8'h00);
    n_checks++;
    if (blk_valid !== 1'b1 || blk_is_key !== 1'b1 || blk_data !== 128'h000102030405060708090A0B0C0D0E0F) begin
      n_fail++; $display("FAIL key_frame: valid=%b key=%b data=%h, required 1/1/000102..0F", blk_valid, blk_is_key, blk_data);
    end
    tick();
    n_checks++;
    if (blk_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL key_valid_one_cycle: valid=%b busy=%b, required 0/0", blk_valid, busy);
    end
    blk_ready = 1'b0;
  endtask

  task automatic test_data_stall();
    int bad = 0;
    blk_ready = 1'b0;
    send_byte(8'h5A);
    for (int i = 0; i < 16; i++) send_byte(8'hFF);
    for (int c = 0; c < 20; c++) begin
      if (blk_valid !== 1'b1 || blk_is_key !== 1'b0 || blk_data !== {128{1'b1}}) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL data_stall_hold: %0d of 20 cycles unstable (valid=%b key=%b data=%h), required 0", bad, blk_valid, blk_is_key, blk_data);
    end
    blk_ready = 1'b1;
    tick();
    n_checks++;
    if (blk_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL data_release: valid=%b busy=%b state=%0d, required 0/0/0", blk_valid, busy, dbg_state);
    end
    blk_ready = 1'b0;
  endtask

  task automatic test_bad_cmd();
    send_byte(8'h3C);
    n_checks++;
    if (err_cmd !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bad_cmd_pulse: err_cmd=%b busy=%b, required 1/0", err_cmd, busy);
    end
    tick();
    n_checks++;
    if (err_cmd !== 1'b0) begin
      n_fail++; $display("FAIL bad_cmd_width: err_cmd=%b, required 0", err_cmd);
    end
    blk_ready = 1'b1;
    send_byte(8'hA5);
    send_payload(8'h10);
    n_checks++;
    if (blk_valid !== 1'b1 || blk_is_key !== 1'b1 || blk_data !== 128'h101112131415161718191A1B1C1D1E1F) begin
      n_fail++; $display("FAIL after_bad_cmd_frame: valid=%b key=%b data=%h, required 1/1/101112..1F", blk_valid, blk_is_key, blk_data);
    end
    tick();
    blk_ready = 1'b0;
  endtask

  task automatic test_overrun();
    blk_ready = 1'b0;
    send_byte(8'h5A);
    send_payload(8'hC0);
    send_byte(8'h5A);
    n_checks++;
    if (err_ovr !== 1'b1 || blk_valid !== 1'b1 || blk_is_key !== 1'b0 || blk_data !== 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF) begin
      n_fail++; $display("FAIL ovr_in_issue: ovr=%b valid=%b key=%b data=%h, required 1/1/0/C0C1..CF", err_ovr, blk_valid, blk_is_key, blk_data);
    end
    tick();
    n_checks++;
    if (err_ovr !== 1'b0) begin
      n_fail++; $display("FAIL ovr_width: err_ovr=%b, required 0", err_ovr);
    end
    // Byte arriving on the handshake cycle itself.
    blk_ready = 1'b1;
    rx_byte   = 8'h5A;
    rx_done   = 1'b1;
    tick();
    rx_done   = 1'b0;
    blk_ready = 1'b0;
    n_checks++;
    if (err_ovr !== 1'b1 || blk_valid !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL ovr_on_handshake: ovr=%b valid=%b state=%0d, required 1/0/0", err_ovr, blk_valid, dbg_state);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0 || err_ovr !== 1'b0) begin
      n_fail++; $display("FAIL ovr_stays_idle: busy=%b state=%0d ovr=%b, required 0/0/0", busy, dbg_state, err_ovr);
    end
  endtask

  task automatic test_mid_reset();
    send_byte(8'h5A);
    for (int i = 0; i < 7; i++) send_byte(8'h80 + 8'(i));
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({blk_valid, busy, blk_is_key, err_cmd, err_ovr, err_tmo} !== 6'b0 || blk_data !== 128'h0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL mid_reset: valid=%b busy=%b key=%b errs=%b%b%b data=%h state=%0d, required all 0",
                         blk_valid, busy, blk_is_key, err_cmd, err_ovr, err_tmo, blk_data, dbg_state);
    end
    tick();
    reset = 1'b1;
    tick();
    blk_ready = 1'b1;
    send_byte(8'hA5);
    send_payload(8'h20);
    n_checks++;
    if (blk_valid !== 1'b1 || blk_is_key !== 1'b1 || blk_data !== 128'h202122232425262728292A2B2C2D2E2F) begin
      n_fail++; $display("FAIL post_reset_frame: valid=%b key=%b data=%h, required 1/1/202122..2F", blk_valid, blk_is_key, blk_data);
    end
    tick();
    blk_ready = 1'b0;
  endtask

`ifdef RX_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    int busy_lost = 0;
    send_byte(8'hA5);
    for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i));
    while (n < 200 && err_tmo !== 1'b1) begin
      tick();
      n++;
      if (err_tmo !== 1'b1 && busy !== 1'b1) busy_lost++;
    end
    n_checks++;
    if (n != 100) begin
      n_fail++; $display("FAIL timeout_latency: err_tmo after %0d cycles, required 100", n);
    end
    n_checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0 || busy_lost != 0) begin
      n_fail++; $display("FAIL timeout_idle: busy=%b state=%0d early_idle=%0d, required 0/0/0", busy, dbg_state, busy_lost);
    end
    tick();
    n_checks++;
    if (err_tmo !== 1'b0) begin
      n_fail++; $display("FAIL timeout_width: err_tmo=%b, required 0", err_tmo);
    end
  endtask
`else
  task automatic test_no_timeout();
    int tmo_seen = 0;
    blk_ready = 1'b1;
    send_byte(8'hA5);
    for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i));
    for (int c = 0; c < 150; c++) begin
      if (err_tmo !== 1'b0) tmo_seen++;
      tick();
    end
    n_checks++;
    if (busy !== 1'b1 || dbg_state !== 2'd1 || tmo_seen != 0) begin
      n_fail++; $display("FAIL no_timeout_wait: busy=%b state=%0d tmo_cycles=%0d, required 1/1/0", busy, dbg_state, tmo_seen);
    end
    for (int i = 3; i < 16; i++) send_byte(8'h30 + 8'(i));
    n_checks++;
    if (blk_valid !== 1'b1 || blk_is_key !== 1'b1 || blk_data !== 128'h303132333435363738393A3B3C3D3E3F) begin
      n_fail++; $display("FAIL no_timeout_frame: valid=%b key=%b data=%h, required 1/1/303132..3F", blk_valid, blk_is_key, blk_data);
    end
    tick();
    blk_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_key_frame();
    test_data_stall();
    test_bad_cmd();
    test_overrun();
    test_mid_reset();
`ifdef RX_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
